// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with 2**FIFO_DEPTH entries, registered read data and level flags.
// Define FIFO_SYNC_PARAM_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clear.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 5,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    output logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  read_en,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [FIFO_DEPTH:0]   fill_count
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
    ,
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int N = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] FULL_CNT = N[FIFO_DEPTH:0];
    localparam logic [FIFO_DEPTH:0] AF_CNT   = AF_LEVEL[FIFO_DEPTH:0];
    localparam logic [FIFO_DEPTH:0] AE_CNT   = AE_LEVEL[FIFO_DEPTH:0];
    localparam logic [FIFO_DEPTH:0] ONE      = {{FIFO_DEPTH{1'b0}}, 1'b1};

    generate
        if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= N)) begin : g_bad_levels
            $error("fifo_sync_param: require 1 <= AE_LEVEL < AF_LEVEL <= 2**FIFO_DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [0:N-1];
    logic [FIFO_DEPTH:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH:0]   fill_q, fill_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_acc, rd_acc;

    // Handshake: write_en/read_en are requests sampled on the rising edge; a request is
    // accepted only if the registered full/empty flag allows it, otherwise it has no effect.
    assign fifo_full    = (fill_q == FULL_CNT);
    assign fifo_empty   = (fill_q == '0);
    assign almost_full  = (fill_q >= AF_CNT);
    assign almost_empty = (fill_q <= AE_CNT);
    assign fill_count   = fill_q;
    assign data_out     = data_out_q;

    assign wr_acc = write_en & ~fifo_full;
    assign rd_acc = read_en & ~fifo_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        data_out_d = data_out_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + ONE;
            data_out_d = mem_q[rd_ptr_q[FIFO_DEPTH-1:0]];
        end
        if (wr_acc && !rd_acc) fill_d = fill_q + ONE;
        else if (rd_acc && !wr_acc) fill_d = fill_q - ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately not reset; clearing the pointers discards its contents.
    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[wr_ptr_q[FIFO_DEPTH-1:0]] <= data_in;
    end

`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A rejection in the same cycle as err_clear keeps the flag set.
    assign overflow_d  = (write_en & fifo_full) | (overflow_q & ~err_clear);
    assign underflow_d = (read_en & fifo_empty) | (underflow_q & ~err_clear);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: fill/drain, full/empty corner cases, streaming across
// pointer wrap, asynchronous reset mid-operation, and optional error flags.
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NE = 32;
    localparam int AF = 28;
    localparam int AE = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] data_in;
    logic          write_en;
    logic          read_en;
    logic          fifo_full, fifo_empty, almost_full, almost_empty;
    logic [DW-1:0] data_out;
    logic [AW:0]   fill_count;
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
    logic          err_clear;
    logic          overflow, underflow;
`endif

    fifo_sync_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .write_en     (write_en),
        .fifo_full    (fifo_full),
        .data_out     (data_out),
        .read_en      (read_en),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count)
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        ,
        .err_clear    (err_clear),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".count"}, 32'(fill_count), 32'(m_count));
        check_val({tag, ".dout"},  32'(data_out), 32'(m_dout));
        check_val({tag, ".full"},  32'(fifo_full), 32'(m_count == NE));
        check_val({tag, ".empty"}, 32'(fifo_empty), 32'(m_count == 0));
        check_val({tag, ".af"},    32'(almost_full), 32'(m_count >= AF));
        check_val({tag, ".ae"},    32'(almost_empty), 32'(m_count <= AE));
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        check_val({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        check_val({tag, ".udf"},   32'(underflow), 32'(m_udf));
`endif
    endtask

    // One clock: drive requests, update the model from pre-edge state, check after the edge.
    task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] din,
                        input logic clr);
        logic wacc, racc;
        write_en = we;
        read_en  = re;
        data_in  = din;
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        err_clear = clr;
`endif
        wacc = we && (m_count < NE);
        racc = re && (m_count > 0);
        m_ovf = (we && m_count == NE) || (m_ovf && !clr);
        m_udf = (re && m_count == 0) || (m_udf && !clr);
        @(posedge clock);
        if (racc) m_dout = exp_q.pop_front();
        if (wacc) exp_q.push_back(din);
        if (wacc && !racc) m_count++;
        if (racc && !wacc) m_count--;
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        err_clear = 1'b0;
`endif
        check_outputs(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        err_clear = 1'b0;
`endif
        #3;
        check_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // fill 0x00..0x1F
        for (int i = 0; i < NE; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        check_val("fill.count32", 32'(fill_count), 32'd32);
        check_val("fill.full", 32'(fifo_full), 32'd1);

`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        step("ovf_set", 1'b1, 1'b0, 8'h77, 1'b0);
        check_val("ovf.set", 32'(overflow), 32'd1);
        step("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("ovf.hold", 32'(overflow), 32'd1);
        step("ovf_setwins", 1'b1, 1'b0, 8'h78, 1'b1);
        check_val("ovf.setwins", 32'(overflow), 32'd1);
        step("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("ovf.clr", 32'(overflow), 32'd0);
`endif

        // simultaneous read/write at full: read wins, 0xAA dropped
        step("full_rw", 1'b1, 1'b1, 8'hAA, 1'b0);
        check_val("full_rw.dout", 32'(data_out), 32'h00);
        check_val("full_rw.count", 32'(fill_count), 32'd31);

        for (int i = 1; i < NE; i++) begin
            step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
            check_val("drain.data", 32'(data_out), 32'(i));
        end
        check_val("drain.empty", 32'(fifo_empty), 32'd1);

`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
        step("udf_set", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("udf.set", 32'(underflow), 32'd1);
        step("udf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // simultaneous read/write at empty: write wins, data_out holds
        step("empty_rw", 1'b1, 1'b1, 8'h55, 1'b0);
        check_val("empty_rw.count", 32'(fill_count), 32'd1);
        check_val("empty_rw.dout", 32'(data_out), 32'h1F);
        step("empty_rw_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("empty_rw_rd.data", 32'(data_out), 32'h55);

        // streaming at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            step("stream", 1'b1, 1'b1, 8'(i * 7 + 3), 1'b0);
            check_val("stream.ae", 32'(almost_empty), 32'd1);
        end

        // async reset mid-cycle at fill_count 10
        for (int i = 0; i < 7; i++) step("to10", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        check_val("to10.count", 32'(fill_count), 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_count = 0;
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check_val("arst.count", 32'(fill_count), 32'd0);
        check_val("arst.empty", 32'(fifo_empty), 32'd1);
        check_val("arst.dout", 32'(data_out), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step("post_wr", 1'b1, 1'b0, 8'h3C, 1'b0);
        step("post_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("post.data", 32'(data_out), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 5, address width; entry count N = 2**FIFO_DEPTH.
REQ-003 The block SHALL have parameter AF_LEVEL, default 28, fill level at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, fill level at or below which almost_empty asserts.
REQ-005 The block SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-008 The block SHALL have port write_en, input, 1, write request.
REQ-009 The block SHALL have port fifo_full, output, 1, fill level equals N.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-011 The block SHALL have port read_en, input, 1, read request.
REQ-012 The block SHALL have port fifo_empty, output, 1, fill level equals 0.
REQ-013 The block SHALL have port almost_full, output, 1, fill_count >= AF_LEVEL.
REQ-014 The block SHALL have port almost_empty, output, 1, fill_count <= AE_LEVEL.
REQ-015 The block SHALL have port fill_count, output, FIFO_DEPTH+1, current number of stored entries (0..N).

Function
REQ-016 Write pointer, read pointer SHALL be FIFO_DEPTH+1-bit binary counters; low FIFO_DEPTH bits address storage, MSB is wrap flag; increment wraps 2N-1 -> 0.
REQ-017 A write SHALL be accepted when write_en=1 and fifo_full=0 (state before the edge); data_in stored at write address, write pointer +1.
REQ-018 A read SHALL be accepted when read_en=1 and fifo_empty=0 (state before the edge); read pointer +1.
REQ-019 On an accepted read, data_out SHALL present the entry at the pre-increment read address on the next edge (latency 1); otherwise data_out holds.
REQ-020 fill_count SHALL update on the edge: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-021 fifo_full, fifo_empty, almost_full, almost_empty SHALL be combinational decodes of registered fill_count only (no dependence on current-cycle inputs).
REQ-022 At full, simultaneous read_en and write_en: read accepted, write rejected; fill_count becomes N-1.
REQ-023 At empty, simultaneous read_en and write_en: write accepted, read rejected, data_out holds; fill_count becomes 1.
REQ-024 Rejected requests SHALL leave storage, pointers and fill_count unchanged.
REQ-025 Elaboration SHALL fail unless 1 <= AE_LEVEL < AF_LEVEL <= N.

Reset
REQ-026 reset_n low SHALL immediately clear pointers, fill_count and data_out to 0, regardless of clock.
REQ-027 After reset, outputs SHALL be fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fill_count=0.
REQ-028 Storage array SHALL NOT be reset; reset mid-operation discards all contents.
REQ-029 reset_n deassertion SHALL be synchronised externally; first accepted op is at the first edge with reset_n high.

Configuration
REQ-030 Macro FIFO_SYNC_PARAM_ERR_FLAGS_EN defined SHALL add ports err_clear (input, 1), overflow (output, 1), underflow (output, 1).
REQ-031 With the macro, overflow SHALL set sticky on an edge where write_en=1 is rejected; underflow likewise for rejected read_en; both cleared by err_clear=1; set wins over clear in the same cycle; both reset to 0.
REQ-032 Without the macro, those ports and registers SHALL be absent and rejected requests dropped silently.

Verification
REQ-033 Reset, then 32 writes 0x00..0x1F -> fill_count 32, fifo_full=1, almost_full asserted at count 28; 32 reads return 0x00..0x1F each one cycle after read_en.
REQ-034 At full, write_en+read_en one cycle with data_in=0xAA -> data_out=0x00, fill_count=31, 0xAA never read back.
REQ-035 At empty, write_en+read_en with data_in=0x55 -> fill_count=1, data_out unchanged, next read returns 0x55.
REQ-036 Streaming 100 writes/reads with occupancy held at 3 -> in-order data across pointer wrap, almost_empty=1 throughout.
REQ-037 reset_n pulsed low mid-clock at fill_count=10 -> fill_count=0, fifo_empty=1, data_out=0 before next edge.
REQ-038 With FIFO_SYNC_PARAM_ERR_FLAGS_EN: write at full -> overflow=1 held until err_clear; read at empty -> underflow=1; err_clear with coincident overflow event -> overflow stays 1.
